// File: rtl/scale_job_controller_pkg.sv
// Shared scaling definitions: algorithm/zoom codes, FSM encoding and default timing.
package scale_job_controller_pkg;

  localparam int unsigned ALG_W  = 2;
  localparam int unsigned ZOOM_W = 3;
  localparam int unsigned CNT_W  = 21;

  localparam int unsigned CLEAR_CYCLES_DEFAULT   = 2;
  localparam int unsigned TIMEOUT_CYCLES_DEFAULT = 1228864;

  typedef enum logic [ALG_W-1:0] {
    ALG_NN  = 2'b00,
    ALG_PR  = 2'b01,
    ALG_DEC = 2'b10,
    ALG_BA  = 2'b11
  } alg_e;

  localparam logic [ZOOM_W-1:0] ZOOM_QUARTER = 3'd0;
  localparam logic [ZOOM_W-1:0] ZOOM_HALF    = 3'd1;
  localparam logic [ZOOM_W-1:0] ZOOM_1X      = 3'd2;
  localparam logic [ZOOM_W-1:0] ZOOM_2X      = 3'd3;
  localparam logic [ZOOM_W-1:0] ZOOM_4X      = 3'd4;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_CLEAR     = 2'd1,
    ST_RUN       = 2'd2,
    ST_WAIT_SWAP = 2'd3
  } state_e;

  typedef struct packed {
    logic [ALG_W-1:0]  algorithm;
    logic [ZOOM_W-1:0] zoom;
  } scale_cmd_t;

endpackage

// File: rtl/scale_cmd_validator.sv
// Combinational legality check of an (algorithm, zoom) scaling command.
module scale_cmd_validator
  import scale_job_controller_pkg::*;
(
  input  logic [ALG_W-1:0]  algorithm_i,
  input  logic [ZOOM_W-1:0] zoom_i,
  output logic              legal_c_o
);

  always_comb begin
    legal_c_o = 1'b0;
    case (alg_e'(algorithm_i))
      ALG_NN:          legal_c_o = (zoom_i <= ZOOM_4X);
      ALG_PR:          legal_c_o = (zoom_i >= ZOOM_1X) && (zoom_i <= ZOOM_4X);
      ALG_DEC, ALG_BA: legal_c_o = (zoom_i <= ZOOM_1X);
      default:         legal_c_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/scale_job_controller.sv
// Sequences one scaling job: validate, clear-then-enable the datapath, wait for done,
// then swap the framebuffer banks on the next vsync.
module scale_job_controller
  import scale_job_controller_pkg::*;
#(
  parameter int unsigned CLEAR_CYCLES   = CLEAR_CYCLES_DEFAULT,
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [ALG_W-1:0]  cmd_algorithm,
  input  logic [ZOOM_W-1:0] cmd_zoom,
  input  logic              abort,
  output logic              proc_enable,
  output logic [ALG_W-1:0]  proc_algorithm,
  output logic [ZOOM_W-1:0] proc_zoom,
  input  logic              proc_done,
  input  logic              vsync_pulse,
  output logic              buf_sel_write,
  output logic              buf_sel_display,
  output logic              busy,
  output logic              frame_done,
  output logic              err_invalid,
  output logic              err_timeout
);

  localparam int unsigned CLR_W = (CLEAR_CYCLES > 1) ? $clog2(CLEAR_CYCLES) : 1;

  state_e            state_q;
  scale_cmd_t        cfg_q;
  logic [CLR_W-1:0]  clear_cnt_q;
  logic [CNT_W-1:0]  timeout_cnt_q;
  logic              proc_enable_q;
  logic              buf_write_q;
  logic              buf_display_q;
  logic              frame_done_q;
  logic              err_invalid_q;
  logic              err_timeout_q;

  logic              cmd_legal;
  logic              accept;
  logic              clear_last;
  logic              timeout_hit;

  scale_cmd_validator u_validator (
    .algorithm_i (cmd_algorithm),
    .zoom_i      (cmd_zoom),
    .legal_c_o   (cmd_legal)
  );

  assign cmd_ready   = (state_q == ST_IDLE) && !reset;
  assign busy        = (state_q != ST_IDLE);
  assign accept      = cmd_valid && cmd_ready;
  assign clear_last  = (clear_cnt_q == CLR_W'(CLEAR_CYCLES - 1));
  assign timeout_hit = (timeout_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  // Job FSM; abort outranks done/vsync/timeout, done outranks timeout.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      cfg_q         <= '{algorithm: ALG_W'(ALG_NN), zoom: ZOOM_1X};
      clear_cnt_q   <= '0;
      timeout_cnt_q <= '0;
      proc_enable_q <= 1'b0;
      buf_write_q   <= 1'b1;
      buf_display_q <= 1'b0;
      frame_done_q  <= 1'b0;
      err_invalid_q <= 1'b0;
      err_timeout_q <= 1'b0;
    end else begin
      frame_done_q  <= 1'b0;
      err_invalid_q <= 1'b0;
      err_timeout_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            if (cmd_legal) begin
              cfg_q       <= '{algorithm: cmd_algorithm, zoom: cmd_zoom};
              clear_cnt_q <= '0;
              state_q     <= ST_CLEAR;
            end else begin
              err_invalid_q <= 1'b1;
            end
          end
        end
        ST_CLEAR: begin
          if (abort) begin
            state_q <= ST_IDLE;
          end else if (clear_last) begin
            state_q       <= ST_RUN;
            proc_enable_q <= 1'b1;
            timeout_cnt_q <= '0;
          end else begin
            clear_cnt_q <= clear_cnt_q + CLR_W'(1);
          end
        end
        ST_RUN: begin
          if (abort) begin
            state_q       <= ST_IDLE;
            proc_enable_q <= 1'b0;
            timeout_cnt_q <= '0;
          end else if (proc_done) begin
            state_q       <= ST_WAIT_SWAP;
            proc_enable_q <= 1'b0;
            timeout_cnt_q <= '0;
          end else if (timeout_hit) begin
            state_q       <= ST_IDLE;
            proc_enable_q <= 1'b0;
            err_timeout_q <= 1'b1;
            timeout_cnt_q <= '0;
          end else begin
            timeout_cnt_q <= timeout_cnt_q + CNT_W'(1);
          end
        end
        ST_WAIT_SWAP: begin
          if (abort) begin
            state_q <= ST_IDLE;
          end else if (vsync_pulse) begin
            buf_write_q   <= ~buf_write_q;
            buf_display_q <= ~buf_display_q;
            frame_done_q  <= 1'b1;
            state_q       <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign proc_enable     = proc_enable_q;
  assign proc_algorithm  = cfg_q.algorithm;
  assign proc_zoom       = cfg_q.zoom;
  assign buf_sel_write   = buf_write_q;
  assign buf_sel_display = buf_display_q;
  assign frame_done      = frame_done_q;
  assign err_invalid     = err_invalid_q;
  assign err_timeout     = err_timeout_q;

endmodule

// File: tb/tb_scale_job_controller.sv
// Directed bench for scale_job_controller; a second instance uses a short timeout.
module tb_scale_job_controller;

  logic       clk = 1'b0;
  logic       reset, cmd_valid, abort, proc_done, vsync_pulse;
  logic [1:0] cmd_algorithm;
  logic [2:0] cmd_zoom;

  logic       cmd_ready, proc_enable, buf_sel_write, buf_sel_display;
  logic       busy, frame_done, err_invalid, err_timeout;
  logic [1:0] proc_algorithm;
  logic [2:0] proc_zoom;

  logic       cmd_ready_t, proc_enable_t, buf_sel_write_t, buf_sel_display_t;
  logic       busy_t, frame_done_t, err_invalid_t, err_timeout_t;
  logic [1:0] proc_algorithm_t;
  logic [2:0] proc_zoom_t;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  scale_job_controller dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_algorithm(cmd_algorithm), .cmd_zoom(cmd_zoom), .abort(abort),
    .proc_enable(proc_enable), .proc_algorithm(proc_algorithm), .proc_zoom(proc_zoom),
    .proc_done(proc_done), .vsync_pulse(vsync_pulse), .buf_sel_write(buf_sel_write),
    .buf_sel_display(buf_sel_display), .busy(busy), .frame_done(frame_done),
    .err_invalid(err_invalid), .err_timeout(err_timeout)
  );

  scale_job_controller #(.TIMEOUT_CYCLES(50)) dut_to (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready_t),
    .cmd_algorithm(cmd_algorithm), .cmd_zoom(cmd_zoom), .abort(abort),
    .proc_enable(proc_enable_t), .proc_algorithm(proc_algorithm_t), .proc_zoom(proc_zoom_t),
    .proc_done(proc_done), .vsync_pulse(vsync_pulse), .buf_sel_write(buf_sel_write_t),
    .buf_sel_display(buf_sel_display_t), .busy(busy_t), .frame_done(frame_done_t),
    .err_invalid(err_invalid_t), .err_timeout(err_timeout_t)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Legal command from IDLE through to the first WAIT_SWAP cycle (no checks).
  task automatic run_to_wait(input logic [1:0] alg, input logic [2:0] zoom);
    cmd_valid = 1'b1; cmd_algorithm = alg; cmd_zoom = zoom;
    tick();
    cmd_valid = 1'b0;
    tick();
    tick();
    proc_done = 1'b1;
    tick();
    proc_done = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; cmd_valid = 1'b1; cmd_algorithm = 2'd0; cmd_zoom = 3'd3;
    tick();
    tick();
    checks++;
    if (cmd_ready !== 1'b0) begin
      errors++; $display("FAIL reset_ready: got %b expected 0", cmd_ready);
    end
    checks++;
    if ({busy, proc_enable, buf_sel_write, buf_sel_display} !== 4'b0010) begin
      errors++; $display("FAIL reset_state: got %b expected 0010",
                         {busy, proc_enable, buf_sel_write, buf_sel_display});
    end
    checks++;
    if ({proc_algorithm, proc_zoom} !== {2'd0, 3'd2}) begin
      errors++; $display("FAIL reset_cfg: got %b expected 00010", {proc_algorithm, proc_zoom});
    end
    checks++;
    if ({frame_done, err_invalid, err_timeout} !== 3'b000) begin
      errors++; $display("FAIL reset_pulses: got %b expected 000",
                         {frame_done, err_invalid, err_timeout});
    end
    cmd_valid = 1'b0;
    reset = 1'b0;
    #1;
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++; $display("FAIL reset_release_ready: got %b expected 1", cmd_ready);
    end
  endtask

  task automatic test_legal_job();
    int lows, highs, fd;
    cmd_valid = 1'b1; cmd_algorithm = 2'd0; cmd_zoom = 3'd3;
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++; $display("FAIL job_ready: got %b expected 1", cmd_ready);
    end
    tick();
    cmd_valid = 1'b0;
    checks++;
    if ({busy, proc_algorithm, proc_zoom} !== {1'b1, 2'd0, 3'd3}) begin
      errors++; $display("FAIL job_latch: got %b expected 100011", {busy, proc_algorithm, proc_zoom});
    end
    lows = 0;
    while (proc_enable === 1'b0 && lows < 10) begin
      lows++;
      tick();
    end
    checks++;
    if (lows != 2) begin
      errors++; $display("FAIL job_clear_len: got %0d expected 2", lows);
    end
    highs = 0;
    for (int i = 1; i <= 100; i++) begin
      if (proc_enable === 1'b1) highs++;
      if (i == 100) proc_done = 1'b1;
      tick();
    end
    proc_done = 1'b0;
    checks++;
    if (highs != 100) begin
      errors++; $display("FAIL job_run_len: got %0d expected 100", highs);
    end
    checks++;
    if ({proc_enable, busy, buf_sel_write, buf_sel_display} !== 4'b0110) begin
      errors++; $display("FAIL job_wait_state: got %b expected 0110",
                         {proc_enable, busy, buf_sel_write, buf_sel_display});
    end
    fd = 0;
    for (int i = 0; i < 19; i++) begin
      if (frame_done === 1'b1) fd++;
      tick();
    end
    vsync_pulse = 1'b1;
    tick();
    vsync_pulse = 1'b0;
    if (frame_done === 1'b1) fd++;
    checks++;
    if ({busy, buf_sel_write, buf_sel_display} !== 3'b001) begin
      errors++; $display("FAIL job_swap: got %b expected 001", {busy, buf_sel_write, buf_sel_display});
    end
    tick();
    if (frame_done === 1'b1) fd++;
    checks++;
    if (fd != 1) begin
      errors++; $display("FAIL job_frame_done_count: got %0d expected 1", fd);
    end
  endtask

  task automatic test_illegal();
    logic [1:0] algs [2];
    logic [2:0] zooms [2];
    int rises;
    algs[0] = 2'd3; zooms[0] = 3'd4;
    algs[1] = 2'd1; zooms[1] = 3'd1;
    for (int k = 0; k < 2; k++) begin
      cmd_valid = 1'b1; cmd_algorithm = algs[k]; cmd_zoom = zooms[k];
      checks++;
      if (cmd_ready !== 1'b1) begin
        errors++; $display("FAIL illegal_ready[%0d]: got %b expected 1", k, cmd_ready);
      end
      tick();
      cmd_valid = 1'b0;
      checks++;
      if ({err_invalid, busy, proc_enable} !== 3'b100) begin
        errors++; $display("FAIL illegal_pulse[%0d]: got %b expected 100", k,
                           {err_invalid, busy, proc_enable});
      end
      checks++;
      if ({proc_algorithm, proc_zoom} !== {2'd0, 3'd3}) begin
        errors++; $display("FAIL illegal_cfg[%0d]: got %b expected 00011", k,
                           {proc_algorithm, proc_zoom});
      end
      tick();
      checks++;
      if ({err_invalid, busy} !== 2'b00) begin
        errors++; $display("FAIL illegal_after[%0d]: got %b expected 00", k, {err_invalid, busy});
      end
    end
    rises = 0;
    for (int i = 0; i < 5; i++) begin
      if (proc_enable === 1'b1 || busy === 1'b1) rises++;
      tick();
    end
    checks++;
    if (rises != 0) begin
      errors++; $display("FAIL illegal_no_run: got %0d active cycles expected 0", rises);
    end
  endtask

  task automatic test_back_to_back();
    cmd_valid = 1'b1; cmd_algorithm = 2'd2; cmd_zoom = 3'd0;
    tick();
    cmd_algorithm = 2'd1; cmd_zoom = 3'd4;
    checks++;
    if ({cmd_ready, busy, proc_algorithm, proc_zoom} !== {1'b0, 1'b1, 2'd2, 3'd0}) begin
      errors++; $display("FAIL b2b_first: got %b expected 0110000",
                         {cmd_ready, busy, proc_algorithm, proc_zoom});
    end
    tick();
    checks++;
    if (cmd_ready !== 1'b0) begin
      errors++; $display("FAIL b2b_ready_clear: got %b expected 0", cmd_ready);
    end
    tick();
    checks++;
    if ({cmd_ready, proc_enable} !== 2'b01) begin
      errors++; $display("FAIL b2b_ready_run: got %b expected 01", {cmd_ready, proc_enable});
    end
    proc_done = 1'b1;
    tick();
    proc_done = 1'b0;
    tick();
    vsync_pulse = 1'b1;
    checks++;
    if ({cmd_ready, busy} !== 2'b01) begin
      errors++; $display("FAIL b2b_ready_wait: got %b expected 01", {cmd_ready, busy});
    end
    tick();
    vsync_pulse = 1'b0;
    checks++;
    if ({frame_done, cmd_ready, busy, buf_sel_write, buf_sel_display} !== 5'b11010) begin
      errors++; $display("FAIL b2b_swap: got %b expected 11010",
                         {frame_done, cmd_ready, busy, buf_sel_write, buf_sel_display});
    end
    tick();
    checks++;
    if ({frame_done, busy, cmd_ready, proc_algorithm, proc_zoom} !== {3'b010, 2'd1, 3'd4}) begin
      errors++; $display("FAIL b2b_second: got %b expected 01001100",
                         {frame_done, busy, cmd_ready, proc_algorithm, proc_zoom});
    end
    cmd_valid = 1'b0;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    checks++;
    if ({busy, proc_enable, buf_sel_write} !== 3'b001) begin
      errors++; $display("FAIL b2b_abort_clear: got %b expected 001", {busy, proc_enable, buf_sel_write});
    end
  endtask

  task automatic test_timeout();
    int highs;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    cmd_valid = 1'b1; cmd_algorithm = 2'd0; cmd_zoom = 3'd2;
    tick();
    cmd_valid = 1'b0;
    tick();
    tick();
    highs = 0;
    while (proc_enable_t === 1'b1 && highs < 200) begin
      highs++;
      tick();
    end
    checks++;
    if (highs != 50) begin
      errors++; $display("FAIL timeout_run_len: got %0d expected 50", highs);
    end
    checks++;
    if ({err_timeout_t, busy_t, buf_sel_write_t, buf_sel_display_t, frame_done_t} !== 5'b10100) begin
      errors++; $display("FAIL timeout_pulse: got %b expected 10100",
                         {err_timeout_t, busy_t, buf_sel_write_t, buf_sel_display_t, frame_done_t});
    end
    checks++;
    if ({err_timeout, busy, proc_enable} !== 3'b011) begin
      errors++; $display("FAIL timeout_default_inst: got %b expected 011", {err_timeout, busy, proc_enable});
    end
    tick();
    checks++;
    if (err_timeout_t !== 1'b0) begin
      errors++; $display("FAIL timeout_pulse_width: got %b expected 0", err_timeout_t);
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    checks++;
    if ({busy, proc_enable, buf_sel_write, busy_t} !== 4'b0010) begin
      errors++; $display("FAIL timeout_abort: got %b expected 0010", {busy, proc_enable, buf_sel_write, busy_t});
    end
  endtask

  task automatic test_abort_and_reset();
    int fd;
    cmd_valid = 1'b1; cmd_algorithm = 2'd0; cmd_zoom = 3'd1;
    tick();
    cmd_valid = 1'b0;
    tick();
    tick();
    for (int i = 1; i < 10; i++) tick();
    checks++;
    if (proc_enable !== 1'b1) begin
      errors++; $display("FAIL abort_pre_run: got %b expected 1", proc_enable);
    end
    abort = 1'b1; proc_done = 1'b1;
    tick();
    abort = 1'b0; proc_done = 1'b0;
    checks++;
    if ({busy, proc_enable, frame_done, buf_sel_write, buf_sel_display} !== 5'b00010) begin
      errors++; $display("FAIL abort_run: got %b expected 00010",
                         {busy, proc_enable, frame_done, buf_sel_write, buf_sel_display});
    end
    fd = 0;
    for (int i = 0; i < 4; i++) begin
      vsync_pulse = (i == 1);
      tick();
      if (frame_done === 1'b1) fd++;
    end
    vsync_pulse = 1'b0;
    checks++;
    if (fd != 0 || buf_sel_write !== 1'b1) begin
      errors++; $display("FAIL abort_no_swap: got fd=%0d wr=%b expected fd=0 wr=1", fd, buf_sel_write);
    end
    run_to_wait(2'd0, 3'd2);
    tick();
    vsync_pulse = 1'b1;
    tick();
    vsync_pulse = 1'b0;
    checks++;
    if ({buf_sel_write, buf_sel_display} !== 2'b01) begin
      errors++; $display("FAIL prereset_swap: got %b expected 01", {buf_sel_write, buf_sel_display});
    end
    run_to_wait(2'd3, 3'd1);
    checks++;
    if ({busy, proc_enable} !== 2'b10) begin
      errors++; $display("FAIL prereset_wait: got %b expected 10", {busy, proc_enable});
    end
    reset = 1'b1;
    tick();
    checks++;
    if ({buf_sel_write, buf_sel_display, busy, proc_enable, frame_done, cmd_ready} !== 6'b100000) begin
      errors++; $display("FAIL reset_in_wait: got %b expected 100000",
                         {buf_sel_write, buf_sel_display, busy, proc_enable, frame_done, cmd_ready});
    end
    checks++;
    if ({proc_algorithm, proc_zoom} !== {2'd0, 3'd2}) begin
      errors++; $display("FAIL reset_in_wait_cfg: got %b expected 00010", {proc_algorithm, proc_zoom});
    end
    reset = 1'b0;
  endtask

  task automatic test_vsync_on_entry();
    int fd;
    cmd_valid = 1'b1; cmd_algorithm = 2'd1; cmd_zoom = 3'd3;
    tick();
    cmd_valid = 1'b0;
    tick();
    tick();
    proc_done = 1'b1; vsync_pulse = 1'b1;
    tick();
    proc_done = 1'b0; vsync_pulse = 1'b0;
    checks++;
    if ({busy, frame_done, buf_sel_write} !== 3'b101) begin
      errors++; $display("FAIL entry_vsync_ignored: got %b expected 101", {busy, frame_done, buf_sel_write});
    end
    fd = 0;
    for (int i = 0; i < 29; i++) begin
      if (frame_done === 1'b1 || busy !== 1'b1) fd++;
      tick();
    end
    checks++;
    if (fd != 0) begin
      errors++; $display("FAIL entry_hold: got %0d early-exit cycles expected 0", fd);
    end
    vsync_pulse = 1'b1;
    tick();
    vsync_pulse = 1'b0;
    checks++;
    if ({frame_done, busy, buf_sel_write, buf_sel_display} !== 4'b1001) begin
      errors++; $display("FAIL entry_second_vsync: got %b expected 1001",
                         {frame_done, busy, buf_sel_write, buf_sel_display});
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; cmd_valid = 1'b0; cmd_algorithm = 2'd0; cmd_zoom = 3'd0;
    abort = 1'b0; proc_done = 1'b0; vsync_pulse = 1'b0;
    test_reset();
    test_legal_job();
    test_illegal();
    test_back_to_back();
    test_timeout();
    test_abort_and_reset();
    test_vsync_on_entry();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
